// File: rtl/fifo_vc.sv
// Per-virtual-channel FWFT FIFO feeding the VC routing arbiter.
// Registered occupancy drives every flag; the error flag latches overflow/underflow until reset.
module fifo_vc #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Handshake: push/pop are single-cycle requests with no ready return; a push is taken
    // when not full (or when full together with a pop), a pop is taken when not empty.
    // Refused requests are dropped and latch error, except a pop paired with a push on empty.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign data_out     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop_ok)      count <= count + CW'(1);
            else if (pop_ok && !push_ok) count <= count - CW'(1);
            if ((push && !pop && full) || (pop && !push && empty)) error <= 1'b1;
        end
    end

    // Storage is not reset; a push coinciding with reset must not land.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_fifo_vc.sv
// Bench for fifo_vc: directed walk through the boundary cases, then a randomized run,
// all checked against a queue model of FIFO occupancy and sticky error.
module tb_fifo_vc;

    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          error;

    int            compared   = 0;
    int            mismatched = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_err = 1'b0;

    always #5 clk = ~clk;

    fifo_vc #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = exp_q.size();
        chk("count", 32'(count), sz);
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(sz >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
        chk("data_out", 32'(data_out), (sz > 0) ? 32'(exp_q[0]) : 32'h0);
        chk("error", 32'(error), 32'(exp_err));
    endtask

    // Drive one cycle's request at the falling edge, apply the model at the rising edge,
    // then check every output at the next falling edge.
    task automatic cycle(input logic p, input logic [DW-1:0] d, input logic q, input logic r);
        int  sz;
        logic do_pop, do_push;
        push = p; data_in = d; pop = q; reset = r;
        #1;
        if (q && !r && exp_q.size() > 0) chk("pop_head", 32'(data_out), 32'(exp_q[0]));
        @(posedge clk);
        sz = exp_q.size();
        if (r) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            do_pop  = q && (sz > 0);
            do_push = p && (sz < DEPTH || do_pop);
            if (p && !q && sz == DEPTH) exp_err = 1'b1;
            if (q && !p && sz == 0)     exp_err = 1'b1;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(d);
        end
        @(negedge clk);
        push = 1'b0; pop = 1'b0; reset = 1'b0;
        check_all();
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        @(negedge clk);

        // Reset then idle
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_data", 32'(data_out), 0);

        // Three pushes
        cycle(1, 6'h11, 0, 0);
        chk("p1_count", 32'(count), 1);
        chk("p1_empty", 32'(empty), 0);
        cycle(1, 6'h22, 0, 0);
        cycle(1, 6'h33, 0, 0);
        chk("p3_count", 32'(count), 3);
        chk("p3_af", 32'(almost_full), 1);
        chk("p3_head", 32'(data_out), 32'h11);

        // Fill, overflow, drain
        cycle(1, 6'h05, 0, 0);
        chk("fill_full", 32'(full), 1);
        cycle(1, 6'h3F, 0, 0);
        chk("ovf_error", 32'(error), 1);
        chk("ovf_count", 32'(count), 4);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
        chk("drain_empty", 32'(empty), 1);

        // Simultaneous push/pop while full, across wrap
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 6'(i + 1), 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 6'(8'h2A + i), 1, 0);
            chk("full_pp_count", 32'(count), 4);
            chk("full_pp_error", 32'(error), 0);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

        // Push and pop on empty, then underflow
        cycle(1, 6'h07, 1, 0);
        chk("epp_count", 32'(count), 1);
        chk("epp_data", 32'(data_out), 32'h07);
        chk("epp_error", 32'(error), 0);
        cycle(0, 0, 1, 0);
        chk("epp_empty", 32'(empty), 1);
        cycle(0, 0, 1, 0);
        chk("udf_error", 32'(error), 1);

        // Reset wins over push
        for (int i = 0; i < 3; i++) cycle(1, 6'(i + 9), 0, 0);
        cycle(1, 6'h15, 0, 1);
        chk("rstp_count", 32'(count), 0);
        chk("rstp_error", 32'(error), 0);
        chk("rstp_data", 32'(data_out), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 55), 6'($urandom), 1'($urandom_range(0, 99) < 45),
                  1'($urandom_range(0, 99) < 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_vc.md
Name: fifo_vc

Overview:
- Per-virtual-channel FIFO directly upstream of the VC0/VC1 routing arbiter; one instance per channel.
- Producer side: the VC classifier pushes 6-bit words and throttles on `almost_full`.
- Consumer side: the arbiter watches `empty` and asserts `pop`; `data_out` is first-word-fall-through, so the arbiter samples the head word in the same cycle it asserts `pop`.

Parameters:
- DATA_WIDTH, 6, word width (bits [5:4] class/destination, [3:0] payload; opaque to this block).
- DEPTH, 4, number of entries; power of two, ≥2.
- AF_THRESH, 3, `almost_full` asserts when count ≥ AF_THRESH.
- AE_THRESH, 1, `almost_empty` asserts when count ≤ AE_THRESH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write `data_in` this cycle.
- data_in  in  DATA_WIDTH  word to write.
- pop  in  1  consume the head word this cycle.
- data_out  out  DATA_WIDTH  head word (FWFT); 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_THRESH; drives upstream pause.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- error  out  1  sticky overflow/underflow flag.

Behaviour:
- State: memory of DEPTH×DATA_WIDTH; `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits, wrapping naturally DEPTH-1 → 0; registered `count`.

Reset (reset=1 at a clk edge):
- `wr_ptr`, `rd_ptr`, `count`, `error` all return to 0.
- Memory contents do not matter after reset.
- Outputs after reset: `empty`=1, `full`=0, `almost_full`=0, `almost_empty`=1, `data_out`=0, `error`=0.
- Reset wins over push/pop in the same cycle; reset mid-stream discards all entries.

Flags and output:
- `empty`, `full`, `almost_full`, `almost_empty` are combinational decodes of the registered `count`, so they change the cycle after the edge that changes `count`.
- `data_out` = mem[`rd_ptr`] when !`empty`, else 0; purely combinational from registered state.

Push and pop rules:
- Valid push: `push` & !`full` → mem[`wr_ptr`] <= `data_in`, `wr_ptr`++.
- Valid pop: `pop` & !`empty` → `rd_ptr`++.
- Count update: +1 for push only, −1 for pop only, unchanged when both are valid.

Full boundary:
- push & pop together while `full`: both accepted. The pop frees the head slot; the write lands at `wr_ptr` (== `rd_ptr`, the slot being vacated). `count` stays DEPTH.
- push without pop while `full`: write dropped, pointers and count unchanged, `error` <= 1.

Empty boundary:
- push & pop together while `empty`: push accepted, pop ignored (no fall-through bypass). `count` → 1, no error.
- pop without push while `empty`: ignored, `error` <= 1.

Error flag and throughput:
- `error` is sticky; only reset clears it.
- Latency: a word pushed at edge N is visible on `data_out` after edge N, if the FIFO was empty.
- Sustained throughput: 1 push + 1 pop per cycle.
- Data order is strictly FIFO across pointer wrap-around.

Test Plan:
- Reset then idle → `empty`=1, `almost_empty`=1, `full`=0, `count`=0, `data_out`=0, `error`=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles → `count` 1, 2, 3; `almost_full`=1 once `count`=3; `data_out` stays 0x11; `empty` falls one cycle after the first push.
- Fill to 4 (0x11, 0x22, 0x33, 0x05), then push 0x3F alone → `full`=1, `error`=1, `count`=4; 0x3F is never popped; pops return 0x11, 0x22, 0x33, 0x05 in order, then `empty`=1.
- At `full`, push 0x2A with pop in the same cycle for 6 consecutive cycles (0x2A, 0x2B, …) → `count` holds at 4, `error` stays 0, pops return the earlier data then 0x2A, 0x2B in order across pointer wrap.
- Empty FIFO, push 0x07 & pop in the same cycle → `count`=1, `data_out`=0x07, `error`=0. Next cycle, pop alone → `empty`=1. Then pop again on empty → `error`=1.
- With `count`=3 and `error`=1, assert reset with push high → next cycle `count`=0, `empty`=1, `error`=0, nothing written.
